// File: rtl/alu_cmp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmp_pkg
// Purpose  : Shared types and helpers for the comparator arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_cmp_pkg;

    // Widest operand the order-mapping helper can handle.
    localparam int unsigned CMP_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

    // Flipping the MSB of both operands maps unsigned order onto signed order.
    function automatic logic [CMP_MAX_W-1:0] to_signed_order(
        input logic [CMP_MAX_W-1:0] x,
        input logic                 is_unsigned,
        input int unsigned          width = 32
    );
        logic [CMP_MAX_W-1:0] msb_mask;
        msb_mask = {{(CMP_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
        return is_unsigned ? (x ^ msb_mask) : x;
    endfunction

    function automatic logic is_one_hot(input cmp_result_t r);
        return (r == 3'b100) || (r == 3'b010) || (r == 3'b001);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmp_arbiter_comparator.sv
`default_nettype none
// ============================================================================
// Module   : ALU_Comparator
// Purpose  : Purely combinational signed magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
module ALU_Comparator #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  lt_o,
    output logic                  eq_o,
    output logic                  gt_o
);

    assign lt_o = ($signed(a_i) <  $signed(b_i));
    assign eq_o = (a_i == b_i);
    assign gt_o = ($signed(a_i) >  $signed(b_i));

endmodule
`default_nettype wire

// File: rtl/alu_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmp_arbiter
// Purpose  : Round-robin sequencer sharing one comparator among requesters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmp_arbiter
    import alu_cmp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_b_i,
    input  logic [NUM_REQ-1:0]                   req_unsigned_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    input  logic [NUM_REQ-1:0]                   rsp_ready_i,
    output logic                                 rsp_lt_o,
    output logic                                 rsp_eq_o,
    output logic                                 rsp_gt_o,
    output logic                                 busy_o,
    output logic                                 cmp_err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    // Returns {found, index}: the valid requester closest to ptr going upward.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W:0] pick;
        int             best_d;
        int             d;
        pick   = '0;
        best_d = int'(NUM_REQ);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + int'(NUM_REQ) - int'(ptr));
            if (valid[i] && (d < best_d)) begin
                best_d = d;
                pick   = {1'b1, IDX_W'(i)};
            end
        end
        return pick;
    endfunction

    cmp_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       winner_q;
    logic [DATA_WIDTH-1:0]  a_q, b_q;
    logic                   uns_q;
    cmp_result_t            res_q;
    logic                   cmp_err_q;

    logic [IDX_W:0]         pick;
    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]     winner_oh;
    logic                   rsp_fire;
    logic [DATA_WIDTH-1:0]  cmp_a, cmp_b;
    logic                   cmp_lt, cmp_eq, cmp_gt;
    cmp_result_t            cmp_res;

    assign pick      = rr_pick(req_valid_i, rr_ptr_q);
    assign grant_idx = pick[IDX_W-1:0];
    // Gating on rst keeps requests presented during reset from being accepted.
    assign grant_vld = pick[IDX_W] && (state_q == IDLE) && !rst;
    assign winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_q;
    assign rsp_fire  = (state_q == RESPOND) && |(rsp_ready_i & winner_oh);

    assign req_ready_o = grant_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign rsp_valid_o = (state_q == RESPOND) ? winner_oh : '0;
    assign rsp_lt_o    = res_q.lt;
    assign rsp_eq_o    = res_q.eq;
    assign rsp_gt_o    = res_q.gt;
    assign busy_o      = (state_q != IDLE);
    assign cmp_err_o   = cmp_err_q;

    assign cmp_a   = DATA_WIDTH'(to_signed_order(CMP_MAX_W'(a_q), uns_q, DATA_WIDTH));
    assign cmp_b   = DATA_WIDTH'(to_signed_order(CMP_MAX_W'(b_q), uns_q, DATA_WIDTH));
    assign cmp_res = {cmp_lt, cmp_eq, cmp_gt};

    ALU_Comparator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .a_i  (cmp_a),
        .b_i  (cmp_b),
        .lt_o (cmp_lt),
        .eq_o (cmp_eq),
        .gt_o (cmp_gt)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                state_d = RESPOND;
            end
            RESPOND: begin
                if (rsp_fire) begin
                    state_d  = IDLE;
                    rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : (winner_q + 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            uns_q     <= 1'b0;
            res_q     <= '0;
            cmp_err_q <= 1'b0;
        end else begin
            if (grant_vld) begin
                winner_q <= grant_idx;
                a_q      <= req_a_i[grant_idx];
                b_q      <= req_b_i[grant_idx];
                uns_q    <= req_unsigned_i[grant_idx];
            end
            if (state_q == COMPARE) begin
                res_q <= cmp_res;
                if (!is_one_hot(cmp_res)) begin
                    cmp_err_q <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmp_arbiter
// Purpose  : Self-checking bench for alu_cmp_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmp_arbiter;

    localparam int DW = 32;
    localparam int NR = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0][DW-1:0]  req_a, req_b;
    logic [NR-1:0]          req_unsigned;
    logic [NR-1:0]          rsp_valid;
    logic [NR-1:0]          rsp_ready;
    logic                   rsp_lt, rsp_eq, rsp_gt;
    logic                   busy, cmp_err;

    typedef struct {
        int          idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic        uns;
        logic [2:0]  exp;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] flags;
        int         cyc;
    } sb_t;

    vec_t tbl [10];
    sb_t  sb_q [$];
    int   n_vec  = 0;
    int   n_miss = 0;

    alu_cmp_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_a_i        (req_a),
        .req_b_i        (req_b),
        .req_unsigned_i (req_unsigned),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_lt_o       (rsp_lt),
        .rsp_eq_o       (rsp_eq),
        .rsp_gt_o       (rsp_gt),
        .busy_o         (busy),
        .cmp_err_o      (cmp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rsp(input int idx);
        sb_t e;
        chk("rsp_valid", 32'(rsp_valid), 32'(onehot(idx)));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (rsp_valid != '0) begin
                chk("rsp_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'(e.flags));
            end
        end
    endtask

    // One full transaction; stall>0 holds rsp_ready low, frc corrupts the comparator.
    task automatic run_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic uns, input logic [2:0] exp, input int stall, input bit frc);
        sb_t        e;
        logic [2:0] held;
        @(negedge clk);
        req_a[idx]        = a;
        req_b[idx]        = b;
        req_unsigned[idx] = uns;
        req_valid         = onehot(idx);
        rsp_ready         = (stall > 0) ? '0 : '1;
        #1;
        chk("grant", 32'(req_ready), 32'(onehot(idx)));
        e.idx = idx; e.flags = exp; e.cyc = 0;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("cmp_busy", 32'(busy), 32'd1);
        chk("cmp_ready", 32'(req_ready), 32'd0);
        chk("cmp_rsp_valid", 32'(rsp_valid), 32'd0);
        if (frc) force dut.cmp_eq = 1'b1;
        @(negedge clk);
        if (frc) release dut.cmp_eq;
        #1;
        check_rsp(idx);
        if (stall > 0) begin
            held      = {rsp_lt, rsp_eq, rsp_gt};
            req_valid = '1;
            rsp_ready = ~onehot(idx);
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                #1;
                chk("stall_valid", 32'(rsp_valid), 32'(onehot(idx)));
                chk("stall_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'(held));
                chk("stall_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = '1;
            @(negedge clk);
            #1;
            chk("post_stall_idle", 32'(busy), 32'd0);
            chk("post_stall_grant", 32'(req_ready), 32'(onehot((idx + 1) % NR)));
            req_valid = '0;
        end else begin
            @(negedge clk);
            #1;
            chk("idle_again", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  ngr, nrsp, gidx;
        sb_t e;

        tbl[0] = '{0, 32'hFFFF_FFFB, 32'h0000_0003, 1'b0, 3'b100};
        tbl[1] = '{1, 32'hFFFF_FFFB, 32'h0000_0003, 1'b1, 3'b001};
        tbl[2] = '{1, 32'hFFFF_FFFB, 32'h0000_0003, 1'b0, 3'b100};
        tbl[3] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 3'b010};
        tbl[4] = '{1, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b010};
        tbl[5] = '{0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 3'b001};
        tbl[6] = '{0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 3'b100};
        tbl[7] = '{1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 3'b100};
        tbl[8] = '{0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 3'b001};
        tbl[9] = '{1, 32'h1234_5678, 32'h1234_5678, 1'b1, 3'b010};

        rst          = 1'b1;
        req_valid    = 2'b01;
        req_a        = '0;
        req_b        = '0;
        req_unsigned = '0;
        rsp_ready    = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmp_err", 32'(cmp_err), 32'd0);

        // Both requesters continuously valid from reset: expect 0,1,0,1 every 3 cycles.
        @(negedge clk);
        rst             = 1'b0;
        req_a[0]        = 32'd1; req_b[0] = 32'd2; req_unsigned[0] = 1'b0;
        req_a[1]        = 32'd5; req_b[1] = 32'd5; req_unsigned[1] = 1'b1;
        req_valid       = '1;
        rsp_ready       = '1;
        ngr  = 0;
        nrsp = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (req_ready != '0) begin
                gidx = req_ready[1] ? 1 : 0;
                chk("rr_order", 32'(gidx), 32'(ngr % 2));
                chk("rr_grant_cycle", 32'(cyc), 32'(3 * ngr));
                e.idx = gidx; e.flags = (gidx == 1) ? 3'b010 : 3'b100; e.cyc = cyc;
                sb_q.push_back(e);
                ngr++;
            end
            if (rsp_valid != '0) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("rr_rsp_owner", 32'(rsp_valid), 32'(onehot(e.idx)));
                    chk("rr_rsp_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'(e.flags));
                    chk("rr_rsp_latency", 32'(cyc - e.cyc), 32'd2);
                    nrsp++;
                end else begin
                    chk("rr_rsp_unexpected", 32'(rsp_valid), 32'd0);
                end
            end
        end
        chk("rr_grants", 32'(ngr), 32'd4);
        chk("rr_rsps", 32'(nrsp), 32'd4);
        @(negedge clk);
        req_valid = '0;

        for (int i = 0; i < 10; i++) begin
            run_req(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].uns, tbl[i].exp, 0, 1'b0);
        end

        run_req(0, 32'd10, 32'd20, 1'b0, 3'b100, 5, 1'b0);

        // Reset in COMPARE; rr_ptr is 1 here so a grant to 0 afterwards proves it cleared.
        @(negedge clk);
        req_a[0] = 32'd7; req_b[0] = 32'd9; req_unsigned[0] = 1'b0;
        req_valid = 2'b01;
        rsp_ready = '1;
        #1;
        chk("abort_grant", 32'(req_ready), 32'(onehot(0)));
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '1;
        #1;
        chk("abort_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'(onehot(0)));
        req_valid = '0;
        run_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b001, 0, 1'b0);

        // Corrupt the comparator so lt and eq are both set.
        run_req(1, 32'd1, 32'd2, 1'b0, 3'b110, 0, 1'b1);
        chk("cmp_err_set", 32'(cmp_err), 32'd1);
        run_req(0, 32'd3, 32'd3, 1'b0, 3'b010, 0, 1'b0);
        chk("cmp_err_sticky", 32'(cmp_err), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("cmp_err_cleared", 32'(cmp_err), 32'd0);
        rst = 1'b0;

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
